// File: rtl/branch_commit_reporter.sv
// Commit-side reporter: queues committed conditional-branch outcomes for the BHT update port,
// drains one per cycle, and pulses a one-cycle flush on a direction mispredict.
module branch_commit_reporter #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic              commit_is_br,
  input  logic [ADDR_W-1:0] commit_pc,
  input  logic              commit_taken,
  input  logic              commit_pred,
  input  logic [ADDR_W-1:0] commit_target,
  output logic              ena_to_pred,
  output logic              hit_to_pred,
  output logic [ADDR_W-1:0] pc_to_pred,
  output logic              flush_out,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [31:0]       br_cnt,
  output logic [31:0]       miss_cnt,
  output logic              dbg_state
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_fifo_pc [DEPTH];
  logic                r_fifo_tk [DEPTH];
  logic                r_ena, r_hit, r_flush;
  logic [ADDR_W-1:0]   r_pc, r_flush_pc;
  logic [31:0]         r_br_cnt, r_miss_cnt;
  logic                w_accept, w_push, w_pop, w_mispredict;

  // Handshake: a commit transfers on a cycle where commit_valid && commit_ready; ready depends
  // only on registered state, so the ROB may sample it before deciding to present a commit.
  assign commit_ready = (r_state == ST_IDLE) && (r_count < CNT_W'(DEPTH));
  assign w_accept     = commit_valid && commit_ready;
  assign w_push       = w_accept && commit_is_br;
  assign w_pop        = (r_count != '0);
  assign w_mispredict = w_push && (commit_taken != commit_pred);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mispredict) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_IDLE;
        else                  w_hold_nxt  = r_hold_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr] <= commit_pc;
      r_fifo_tk[r_wr_ptr] <= commit_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena <= 1'b0;
      r_hit <= 1'b0;
      r_pc  <= '0;
    end else begin
      r_ena <= w_pop;
      if (w_pop) begin
        r_hit <= r_fifo_tk[r_rd_ptr];
        r_pc  <= r_fifo_pc[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) r_flush_pc <= commit_target;
      if (w_push && (r_br_cnt != 32'hFFFF_FFFF)) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_mispredict && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign ena_to_pred = r_ena;
  assign hit_to_pred = r_hit;
  assign pc_to_pred  = r_pc;
  assign flush_out   = r_flush;
  assign flush_pc    = r_flush_pc;
  assign br_cnt      = r_br_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_branch_commit_reporter.sv
// Bench for branch_commit_reporter: directed steps plus random commits, checked every cycle
// against a queue-based model of the commit/drain/flush rules.
module tb_branch_commit_reporter;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          commit_valid = 1'b0;
  logic          commit_ready;
  logic          commit_is_br = 1'b0;
  logic [AW-1:0] commit_pc = '0;
  logic          commit_taken = 1'b0;
  logic          commit_pred = 1'b0;
  logic [AW-1:0] commit_target = '0;
  logic          ena_to_pred, hit_to_pred, flush_out, dbg_state;
  logic [AW-1:0] pc_to_pred, flush_pc;
  logic [31:0]   br_cnt, miss_cnt;

  int compared   = 0;
  int mismatched = 0;

  // model state: pending updates as {pc, taken}
  logic [AW:0]   exp_q[$];
  int            hold_left;
  logic          exp_ena, exp_hit, exp_flush;
  logic [AW-1:0] exp_pc, exp_fpc;
  logic [31:0]   exp_br, exp_miss;

  branch_commit_reporter #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_is_br(commit_is_br),
    .commit_pc(commit_pc), .commit_taken(commit_taken), .commit_pred(commit_pred),
    .commit_target(commit_target),
    .ena_to_pred(ena_to_pred), .hit_to_pred(hit_to_pred), .pc_to_pred(pc_to_pred),
    .flush_out(flush_out), .flush_pc(flush_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_left = 0;
    exp_ena = 1'b0; exp_hit = 1'b0; exp_flush = 1'b0;
    exp_pc = '0; exp_fpc = '0; exp_br = '0; exp_miss = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ena"},   32'(ena_to_pred), 32'(exp_ena));
    chk({tag, ".hit"},   32'(hit_to_pred), 32'(exp_hit));
    chk({tag, ".pc"},    pc_to_pred, exp_pc);
    chk({tag, ".flush"}, 32'(flush_out), 32'(exp_flush));
    if (exp_flush) chk({tag, ".flush_pc"}, flush_pc, exp_fpc);
    chk({tag, ".br_cnt"},   br_cnt, exp_br);
    chk({tag, ".miss_cnt"}, miss_cnt, exp_miss);
  endtask

  // One clock with the inputs currently applied; model predicts the post-edge outputs.
  task automatic step(input string tag);
    logic          exp_ready, acc, mis;
    logic [AW:0]   e;
    exp_ready = (hold_left == 0) && (exp_q.size() < DEPTH);
    chk({tag, ".ready"}, 32'(commit_ready), 32'(exp_ready));
    acc = commit_valid && exp_ready;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_ena = 1'b1;
      exp_hit = e[0];
      exp_pc  = e[AW:1];
    end else begin
      exp_ena = 1'b0;
    end
    mis = acc && commit_is_br && (commit_taken != commit_pred);
    if (acc && commit_is_br) begin
      exp_q.push_back({commit_pc, commit_taken});
      if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 1;
    end
    exp_flush = mis;
    if (mis) begin
      exp_fpc = commit_target;
      if (exp_miss != 32'hFFFF_FFFF) exp_miss = exp_miss + 1;
      hold_left = HOLD;
    end else if (hold_left > 0) begin
      hold_left--;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input string tag, input logic v, input logic br, input logic [AW-1:0] pc,
                       input logic tk, input logic pr, input logic [AW-1:0] tgt);
    commit_valid = v; commit_is_br = br; commit_pc = pc;
    commit_taken = tk; commit_pred = pr; commit_target = tgt;
    step(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int ena_seen;
    logic [AW-1:0] rpc;
    logic rtk;
    model_reset();

    // T1: reset 3 cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_outputs("t1");
    chk("t1.ready", 32'(commit_ready), 32'd1);

    // T2: correctly predicted taken branch
    drive("t2", 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180);
    idle("t2", 3);
    chk("t2.br_final", br_cnt, 32'd1);

    // T3: mispredict, not taken
    drive("t3", 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h204);
    chk("t3.flush_pc", flush_pc, 32'h204);
    drive("t3.h1", 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h380);
    drive("t3.h2", 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h380);
    idle("t3", 3);
    chk("t3.miss_final", miss_cnt, 32'd1);

    // T4: 20 back-to-back predicted branches
    ena_seen = 0;
    for (int i = 0; i < 20; i++) begin
      rtk = 1'($urandom_range(0, 1));
      drive("t4", 1'b1, 1'b1, 32'h1000 + 32'(i * 4), rtk, rtk, 32'h2000);
      if (ena_to_pred) ena_seen++;
    end
    for (int i = 0; i < 3; i++) begin
      drive("t4.tail", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      if (ena_to_pred) ena_seen++;
    end
    chk("t4.ena_pulses", 32'(ena_seen), 32'd20);

    // T5: mispredict then queued branches, reset mid-drain
    drive("t5", 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h440);
    idle("t5.hold", 2);
    for (int i = 0; i < 3; i++)
      drive("t5.q", 1'b1, 1'b1, 32'h500 + 32'(i * 4), 1'b1, 1'b1, '0);
    commit_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t5.rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("t5.post", 5);

    // T6: saturated branch counter
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    release dut.r_br_cnt;
    exp_br = 32'hFFFF_FFFF;
    drive("t6", 1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h680);
    idle("t6", 2);
    chk("t6.br_sat", br_cnt, 32'hFFFF_FFFF);

    // random traffic
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rtk = 1'($urandom_range(0, 1));
      drive("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rpc, rtk,
            ($urandom_range(0, 5) == 0) ? ~rtk : rtk, $urandom);
    end
    idle("rnd.tail", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
